// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
//   Sequences PC redirects. Each cycle it picks at most one of these actions:
//   mispredict replay, taken branch, or fence hold. It then squashes wrong-path
//   fetch for FLUSH_CYCLES cycles, or holds the PC until memory drains.
//   Every output comes straight from a flop.
//
// Parameters
//   FLUSH_CYCLES   (1..15)  : cycles flush_o is high, counting the redirect cycle
//   FENCE_MAX_WAIT (1..255) : drain cycles before fence_timeout_o is set
//
// Optional feature
//   PC_REDIRECT_TRAP_EN : adds trap_i/trap_vec_i. A trap outranks every other
//                         source in every state and is issued on the replay path.
//
// Ports
//   clk, rst_n                           clock; async active-low reset
//   mispredict_i / mispredict_addr_i     predictor replay request and address
//   branch_taken_i / branch_target_i     resolved taken branch and target
//   fence_req_i, mem_idle_i              fence request; memory-side idle
//   replay_o / replay_addr_o             replay command to the PC
//   branch_o / branch_target_o           branch command to the PC
//   fence_o                              PC hold
//   flush_o                              squash IF/ID
//   fence_timeout_o                      sticky drain-timeout flag
//   redirect_count_o                     replays plus branches, wraps at 2^16
module pc_redirect_ctrl #(
  parameter int FLUSH_CYCLES   = 2,
  parameter int FENCE_MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mispredict_i,
  input  logic [31:0] mispredict_addr_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        fence_req_i,
  input  logic        mem_idle_i,
`ifdef PC_REDIRECT_TRAP_EN
  input  logic        trap_i,
  input  logic [31:0] trap_vec_i,
`endif
  output logic        replay_o,
  output logic [31:0] replay_addr_o,
  output logic        branch_o,
  output logic [31:0] branch_target_o,
  output logic        fence_o,
  output logic        flush_o,
  output logic        fence_timeout_o,
  output logic [15:0] redirect_count_o
);

  typedef enum logic [1:0] {RUN, FLUSH, FENCE_DRAIN} state_e;

  // The redirect cycle is the first flush cycle, so the counter is loaded
  // with the number of flush cycles that remain after it.
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_MAX   = 8'(FENCE_MAX_WAIT);

  state_e      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic        replay_q, replay_d;
  logic [31:0] replay_addr_q, replay_addr_d;
  logic        branch_q, branch_d;
  logic [31:0] branch_tgt_q, branch_tgt_d;
  logic        fence_q, fence_d;
  logic        flush_q, flush_d;
  logic        timeout_q, timeout_d;
  logic [15:0] count_q, count_d;

  // Winner of this cycle's redirect arbitration, if there is one.
  logic        take_rp, take_br;
  logic [31:0] take_addr;

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    wait_d        = wait_q;
    replay_d      = 1'b0;
    replay_addr_d = replay_addr_q;
    branch_d      = 1'b0;
    branch_tgt_d  = branch_tgt_q;
    fence_d       = 1'b0;
    flush_d       = 1'b0;
    timeout_d     = timeout_q;
    count_d       = count_q;
    take_rp       = 1'b0;
    take_br       = 1'b0;
    take_addr     = 32'h0;

    unique case (state_q)
      RUN: begin
        if (mispredict_i) begin
          take_rp   = 1'b1;
          take_addr = mispredict_addr_i;
        end else if (branch_taken_i) begin
          take_br   = 1'b1;
          take_addr = branch_target_i;
        end else if (fence_req_i) begin
          // The hold lasts at least one cycle, even if memory is already idle.
          fence_d = 1'b1;
          wait_d  = 8'h0;
          state_d = FENCE_DRAIN;
        end
      end
      FLUSH: begin
        // Requests seen here come from squashed instructions and are dropped.
        if (flush_cnt_q == 4'h0) begin
          state_d = RUN;
        end else begin
          flush_d     = 1'b1;
          flush_cnt_d = flush_cnt_q - 4'h1;
        end
      end
      FENCE_DRAIN: begin
        if (mispredict_i) begin
          take_rp   = 1'b1;
          take_addr = mispredict_addr_i;
        end else if (branch_taken_i) begin
          take_br   = 1'b1;
          take_addr = branch_target_i;
        end else if (mem_idle_i) begin
          state_d = RUN;
        end else begin
          fence_d = 1'b1;
          // The counter saturates, so a very long drain cannot wrap it past the limit.
          wait_d  = (wait_q == 8'hFF) ? wait_q : wait_q + 8'h1;
          if (wait_d >= WAIT_MAX) timeout_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

`ifdef PC_REDIRECT_TRAP_EN
    if (trap_i) begin
      take_rp   = 1'b1;
      take_br   = 1'b0;
      take_addr = trap_vec_i;
    end
`endif

    // Every redirect follows the same sequence: a strobe, then a flush window.
    // The hold and any remaining flush time are abandoned.
    if (take_rp || take_br) begin
      replay_d    = take_rp;
      branch_d    = take_br;
      if (take_rp) replay_addr_d = take_addr;
      else         branch_tgt_d  = take_addr;
      fence_d     = 1'b0;
      flush_d     = 1'b1;
      flush_cnt_d = FLUSH_INIT;
      count_d     = count_q + 16'h1;
      state_d     = FLUSH;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      flush_cnt_q   <= 4'h0;
      wait_q        <= 8'h0;
      replay_q      <= 1'b0;
      replay_addr_q <= 32'h0;
      branch_q      <= 1'b0;
      branch_tgt_q  <= 32'h0;
      fence_q       <= 1'b0;
      flush_q       <= 1'b0;
      timeout_q     <= 1'b0;
      count_q       <= 16'h0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      wait_q        <= wait_d;
      replay_q      <= replay_d;
      replay_addr_q <= replay_addr_d;
      branch_q      <= branch_d;
      branch_tgt_q  <= branch_tgt_d;
      fence_q       <= fence_d;
      flush_q       <= flush_d;
      timeout_q     <= timeout_d;
      count_q       <= count_d;
    end
  end

  assign replay_o         = replay_q;
  assign replay_addr_o    = replay_addr_q;
  assign branch_o         = branch_q;
  assign branch_target_o  = branch_tgt_q;
  assign fence_o          = fence_q;
  assign flush_o          = flush_q;
  assign fence_timeout_o  = timeout_q;
  assign redirect_count_o = count_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed bench for pc_redirect_ctrl. Two instances share the same stimulus.
// u_dut uses the default parameters. u_to uses FENCE_MAX_WAIT=4 so that the
// timeout can be exercised.
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mispredict_i, branch_taken_i, fence_req_i, mem_idle_i;
  logic [31:0] mispredict_addr_i, branch_target_i;
`ifdef PC_REDIRECT_TRAP_EN
  logic        trap_i;
  logic [31:0] trap_vec_i;
`endif

  logic        replay_o, branch_o, fence_o, flush_o, fence_timeout_o;
  logic [31:0] replay_addr_o, branch_target_o;
  logic [15:0] redirect_count_o;

  logic        t_replay, t_branch, t_fence, t_flush, t_timeout;
  logic [31:0] t_replay_addr, t_branch_target;
  logic [15:0] t_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl u_dut (
    .clk(clk), .rst_n(rst_n),
    .mispredict_i(mispredict_i), .mispredict_addr_i(mispredict_addr_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .fence_req_i(fence_req_i), .mem_idle_i(mem_idle_i),
`ifdef PC_REDIRECT_TRAP_EN
    .trap_i(trap_i), .trap_vec_i(trap_vec_i),
`endif
    .replay_o(replay_o), .replay_addr_o(replay_addr_o),
    .branch_o(branch_o), .branch_target_o(branch_target_o),
    .fence_o(fence_o), .flush_o(flush_o),
    .fence_timeout_o(fence_timeout_o), .redirect_count_o(redirect_count_o)
  );

  pc_redirect_ctrl #(.FLUSH_CYCLES(2), .FENCE_MAX_WAIT(4)) u_to (
    .clk(clk), .rst_n(rst_n),
    .mispredict_i(mispredict_i), .mispredict_addr_i(mispredict_addr_i),
    .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
    .fence_req_i(fence_req_i), .mem_idle_i(mem_idle_i),
`ifdef PC_REDIRECT_TRAP_EN
    .trap_i(trap_i), .trap_vec_i(trap_vec_i),
`endif
    .replay_o(t_replay), .replay_addr_o(t_replay_addr),
    .branch_o(t_branch), .branch_target_o(t_branch_target),
    .fence_o(t_fence), .flush_o(t_flush),
    .fence_timeout_o(t_timeout), .redirect_count_o(t_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Checks the four command strobes and the redirect count of u_dut.
  task automatic chk_cmd(input string tag, input logic rp, input logic br,
                         input logic fn, input logic fl, input logic [15:0] cnt);
    chk({tag, ".replay"}, {31'b0, replay_o}, {31'b0, rp});
    chk({tag, ".branch"}, {31'b0, branch_o}, {31'b0, br});
    chk({tag, ".fence"},  {31'b0, fence_o},  {31'b0, fn});
    chk({tag, ".flush"},  {31'b0, flush_o},  {31'b0, fl});
    chk({tag, ".count"},  {16'b0, redirect_count_o}, {16'b0, cnt});
  endtask

  // Advances to 1 ns after the next rising edge, when outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk_cmd(tag, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk({tag, ".raddr"},  replay_addr_o, 32'h0);
    chk({tag, ".btgt"},   branch_target_o, 32'h0);
    chk({tag, ".tmo"},    {31'b0, fence_timeout_o}, 32'h0);
    chk({tag, ".to_cmd"}, {28'b0, t_replay, t_branch, t_fence, t_flush}, 32'h0);
    chk({tag, ".to_adr"}, t_replay_addr | t_branch_target, 32'h0);
    chk({tag, ".to_cnt"}, {15'b0, t_timeout, t_count}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    mispredict_i = 0; branch_taken_i = 0; fence_req_i = 0; mem_idle_i = 0;
    mispredict_addr_i = 0; branch_target_i = 0;
`ifdef PC_REDIRECT_TRAP_EN
    trap_i = 0; trap_vec_i = 0;
`endif
    tick(); tick();
    chk_all_zero("rst_held");
    rst_n = 1'b1;
    tick();
    chk_all_zero("rst_rel");

    // Mispredict and branch arrive together. The mispredict wins.
    mispredict_i = 1; mispredict_addr_i = 32'h104;
    branch_taken_i = 1; branch_target_i = 32'h999;
    tick();
    chk_cmd("mp_win", 1, 0, 0, 1, 16'd1);
    chk("mp_win.addr", replay_addr_o, 32'h104);
    chk("mp_win.btgt", branch_target_o, 32'h0);
    mispredict_i = 0; branch_taken_i = 0;
    tick();
    chk_cmd("mp_fl2", 0, 0, 0, 1, 16'd1);
    tick();
    chk_cmd("mp_end", 0, 0, 0, 0, 16'd1);
    chk("mp_end.addr", replay_addr_o, 32'h104);

    // A branch, then a second branch inside FLUSH, which is dropped.
    branch_taken_i = 1; branch_target_i = 32'h200;
    tick();
    chk_cmd("br1", 0, 1, 0, 1, 16'd2);
    chk("br1.tgt", branch_target_o, 32'h200);
    branch_target_i = 32'h300;
    tick();
    chk_cmd("br2_drop", 0, 0, 0, 1, 16'd2);
    chk("br2_drop.tgt", branch_target_o, 32'h200);
    branch_taken_i = 0;
    tick();
    chk_cmd("br_end", 0, 0, 0, 0, 16'd2);
    tick();
    chk_cmd("br_idle", 0, 0, 0, 0, 16'd2);

    // Fence that drains after 5 busy cycles. u_to times out on the 4th cycle.
    fence_req_i = 1; mem_idle_i = 0;
    tick();
    chk_cmd("fn_entry", 0, 0, 1, 0, 16'd2);
    fence_req_i = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("fn_hold%0d", i), {31'b0, fence_o}, 32'h1);
      chk($sformatf("to_tmo%0d", i), {31'b0, t_timeout}, (i >= 4) ? 32'h1 : 32'h0);
    end
    mem_idle_i = 1;
    tick();
    chk_cmd("fn_drain", 0, 0, 0, 0, 16'd2);
    chk("fn_tmo", {31'b0, fence_timeout_o}, 32'h0);
    chk("to_sticky", {31'b0, t_timeout}, 32'h1);

    // Fence entered while memory is already idle still holds for one cycle.
    fence_req_i = 1;
    tick();
    chk_cmd("fi_entry", 0, 0, 1, 0, 16'd2);
    fence_req_i = 0;
    tick();
    chk_cmd("fi_drain", 0, 0, 0, 0, 16'd2);
    mem_idle_i = 0;

    // A mispredict during the drain aborts the fence in the same cycle.
    fence_req_i = 1;
    tick();
    chk_cmd("fa_entry", 0, 0, 1, 0, 16'd2);
    fence_req_i = 0; mispredict_i = 1; mispredict_addr_i = 32'h300;
    tick();
    chk_cmd("fa_abort", 1, 0, 0, 1, 16'd3);
    chk("fa_abort.addr", replay_addr_o, 32'h300);
    mispredict_i = 0;
    tick();
    chk_cmd("fa_fl2", 0, 0, 0, 1, 16'd3);
    tick();
    chk_cmd("fa_end", 0, 0, 0, 0, 16'd3);
    chk("to_sticky2", {31'b0, t_timeout}, 32'h1);

`ifdef PC_REDIRECT_TRAP_EN
    // A trap issued during FLUSH still wins and restarts the flush window.
    mispredict_i = 1; mispredict_addr_i = 32'h400;
    tick();
    chk_cmd("tr_mp", 1, 0, 0, 1, 16'd4);
    mispredict_i = 0; trap_i = 1; trap_vec_i = 32'h80;
    tick();
    chk_cmd("tr_hit", 1, 0, 0, 1, 16'd5);
    chk("tr_hit.addr", replay_addr_o, 32'h80);
    trap_i = 0;
    tick();
    chk_cmd("tr_fl2", 0, 0, 0, 1, 16'd5);
    tick();
    chk_cmd("tr_end", 0, 0, 0, 0, 16'd5);
`endif

    // Asserting reset in the middle of a flush clears outputs without a clock edge.
    branch_taken_i = 1; branch_target_i = 32'h500;
    tick();
    chk("mr_pre.branch", {31'b0, branch_o}, 32'h1);
    branch_taken_i = 0;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    tick();
    rst_n = 1'b1;
    // After reset the FSM is in RUN, so a new request is acted on at once.
    mispredict_i = 1; mispredict_addr_i = 32'h600;
    tick();
    chk_cmd("post_rst", 1, 0, 0, 1, 16'd1);
    chk("post_rst.addr", replay_addr_o, 32'h600);
    mispredict_i = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
